// File: rtl/line_refill_ctrl_pkg.sv
// line_refill_ctrl_pkg: shared line geometry, address slice positions and
// refill FSM encoding for the cache line refill controller.
package line_refill_ctrl_pkg;

  localparam int WORDS    = 16;
  localparam int TAG_W    = 25;
  localparam int BEAT_W   = 4;

  // Address slices: tag = [31:7], set index = [6], word offset = [5:2]
  localparam int TAG_MSB  = 31;
  localparam int TAG_LSB  = 7;
  localparam int IDX_BIT  = 6;
  localparam int WORD_MSB = 5;
  localparam int WORD_LSB = 2;
  localparam int LINE_LSB = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_FILL   = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/line_fill_buffer.sv
// line_fill_buffer: 16x32 beat storage, one word written per enabled cycle,
// all words visible in parallel and held until overwritten or reset.
module line_fill_buffer
  import line_refill_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we_i,
  input  logic [BEAT_W-1:0]       idx_i,
  input  logic [31:0]             data_i,
  output logic [WORDS-1:0][31:0]  words_o
);

  logic [WORDS-1:0][31:0] words_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_q <= '0;
    end else if (we_i) begin
      words_q[idx_i] <= data_i;
    end
  end

  assign words_o = words_q;

endmodule

// File: rtl/line_refill_ctrl.sv
// line_refill_ctrl: on a miss, bursts one 64-byte line from memory into the
// fill buffer, then presents it with tag/set/way for a single-cycle commit.
module line_refill_ctrl #(
  parameter int WORDS = line_refill_ctrl_pkg::WORDS,
  parameter int TAG_W = line_refill_ctrl_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             miss,
  input  logic [31:0]      missAddr,
  input  logic             wayIn,
  output logic             memReq,
  output logic [31:0]      memAddr,
  input  logic             memGrant,
  input  logic             memRdValid,
  input  logic [31:0]      memRdData,
  output logic [31:0]      out0,
  output logic [31:0]      out1,
  output logic [31:0]      out2,
  output logic [31:0]      out3,
  output logic [31:0]      out4,
  output logic [31:0]      out5,
  output logic [31:0]      out6,
  output logic [31:0]      out7,
  output logic [31:0]      out8,
  output logic [31:0]      out9,
  output logic [31:0]      out10,
  output logic [31:0]      out11,
  output logic [31:0]      out12,
  output logic [31:0]      out13,
  output logic [31:0]      out14,
  output logic [31:0]      out15,
  output logic [TAG_W-1:0] tagOut,
  output logic             validOut,
  output logic             lineSelect,
  output logic             select,
  output logic             memWrite,
  output logic             busy,
  output logic             done
);

  import line_refill_ctrl_pkg::state_e;
  import line_refill_ctrl_pkg::S_IDLE;
  import line_refill_ctrl_pkg::S_REQ;
  import line_refill_ctrl_pkg::S_FILL;
  import line_refill_ctrl_pkg::S_COMMIT;
  import line_refill_ctrl_pkg::S_DONE;
  import line_refill_ctrl_pkg::TAG_MSB;
  import line_refill_ctrl_pkg::TAG_LSB;
  import line_refill_ctrl_pkg::IDX_BIT;
  import line_refill_ctrl_pkg::LINE_LSB;

  localparam logic [3:0] LAST_BEAT = 4'(WORDS - 1);

  state_e           state_q, state_d;
  logic [3:0]       beat_q, beat_d;
  logic [31:0]      addr_q, addr_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             idx_q, idx_d;
  logic             way_q, way_d;
  logic             beat_we;
  logic             unused_offset;

  logic [line_refill_ctrl_pkg::WORDS-1:0][31:0] line_words;

  assign unused_offset = ^missAddr[LINE_LSB-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      tag_q   <= '0;
      idx_q   <= 1'b0;
      way_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      way_q   <= way_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    way_d   = way_q;
    beat_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          addr_d  = {missAddr[31:LINE_LSB], {LINE_LSB{1'b0}}};
          tag_d   = TAG_W'(missAddr[TAG_MSB:TAG_LSB]);
          idx_d   = missAddr[IDX_BIT];
          way_d   = wayIn;
          state_d = S_REQ;
        end
      end
      // Beats arriving alongside the grant are not yet part of the burst
      S_REQ: begin
        if (memGrant) begin
          beat_d  = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (memRdValid) begin
          beat_we = 1'b1;
          beat_d  = beat_q + 4'd1;
          if (beat_q == LAST_BEAT) begin
            state_d = S_COMMIT;
          end
        end
      end
      S_COMMIT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  line_fill_buffer u_buf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (beat_we),
    .idx_i   (beat_q),
    .data_i  (memRdData),
    .words_o (line_words)
  );

  assign memReq     = (state_q == S_REQ);
  assign memWrite   = (state_q == S_COMMIT);
  assign validOut   = (state_q == S_COMMIT);
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign memAddr    = addr_q;
  assign tagOut     = tag_q;
  assign lineSelect = idx_q;
  assign select     = way_q;

  assign out0  = line_words[0];
  assign out1  = line_words[1];
  assign out2  = line_words[2];
  assign out3  = line_words[3];
  assign out4  = line_words[4];
  assign out5  = line_words[5];
  assign out6  = line_words[6];
  assign out7  = line_words[7];
  assign out8  = line_words[8];
  assign out9  = line_words[9];
  assign out10 = line_words[10];
  assign out11 = line_words[11];
  assign out12 = line_words[12];
  assign out13 = line_words[13];
  assign out14 = line_words[14];
  assign out15 = line_words[15];

endmodule
